// File: rtl/sync_fifo_mc.sv
// Multi-channel single-clock FIFO: NUM_CH queues share one storage array, with an
// advisory full threshold and hard-capacity drop/overflow protection.
module sync_fifo_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESERVE    = 8,
  parameter int NUM_CH     = 4,
  parameter int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [CHW-1:0]                     wr_ch,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               wr_drop,
  output logic [NUM_CH-1:0]                  full,
  output logic [NUM_CH-1:0]                  ovf,
  input  logic [NUM_CH-1:0]                  ovf_clr,
  input  logic                               rd_en,
  input  logic [CHW-1:0]                     rd_ch,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic [NUM_CH-1:0]                  empty,
  output logic [NUM_CH-1:0]                  has_data,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int AW    = CHW + ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] FULL_TH_L = LW'(DEPTH - RESERVE);
  localparam logic [LW-1:0] LVL_ONE_L = LW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_L = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [NUM_CH*DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r [NUM_CH];
  logic [ADDR_WIDTH-1:0] rd_ptr_r [NUM_CH];
  logic [LW-1:0]         level_r  [NUM_CH];
  logic [NUM_CH-1:0]     wr_hit_s;
  logic [NUM_CH-1:0]     rd_hit_s;
  logic [NUM_CH-1:0]     ovf_set_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_sel_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_sel_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [AW-1:0]         wr_addr_s;
  logic [AW-1:0]         rd_addr_s;

  // Per-channel accept decode; a full channel still takes a write when it is popped this cycle.
  always_comb begin
    wr_hit_s     = '0;
    rd_hit_s     = '0;
    ovf_set_s    = '0;
    wr_ptr_sel_s = '0;
    rd_ptr_sel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_hit_s[c]  = rd_en && (rd_ch == CHW'(c)) && (level_r[c] != '0);
      wr_hit_s[c]  = wr_en && (wr_ch == CHW'(c)) && ((level_r[c] != DEPTH_L) || rd_hit_s[c]);
      ovf_set_s[c] = wr_en && (wr_ch == CHW'(c)) && !wr_hit_s[c];
      if (wr_hit_s[c]) begin
        wr_ptr_sel_s = wr_ptr_r[c];
      end else begin
        wr_ptr_sel_s = wr_ptr_sel_s;
      end
      if (rd_hit_s[c]) begin
        rd_ptr_sel_s = rd_ptr_r[c];
      end else begin
        rd_ptr_sel_s = rd_ptr_sel_s;
      end
    end
    wr_ok_s   = |wr_hit_s;
    rd_ok_s   = |rd_hit_s;
    wr_addr_s = {wr_ch, wr_ptr_sel_s};
    rd_addr_s = {rd_ch, rd_ptr_sel_s};
  end

  // Status decode of the registered occupancy counters.
  always_comb begin
    level    = '0;
    full     = '0;
    empty    = '0;
    has_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      level[c*LW +: LW] = level_r[c];
      full[c]           = (level_r[c] >= FULL_TH_L);
      empty[c]          = (level_r[c] == '0);
      has_data[c]       = (level_r[c] != '0);
    end
  end

  // Storage write port; contents survive reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

  // Pointer and level bookkeeping per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        level_r[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_hit_s[c]) wr_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE_L;
        if (rd_hit_s[c]) rd_ptr_r[c] <= rd_ptr_r[c] + PTR_ONE_L;
        case ({wr_hit_s[c], rd_hit_s[c]})
          2'b10:   level_r[c] <= level_r[c] + LVL_ONE_L;
          2'b01:   level_r[c] <= level_r[c] - LVL_ONE_L;
          default: level_r[c] <= level_r[c];
        endcase
      end
    end
  end

  // Registered read data, drop pulse and sticky overflow (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_drop  <= 1'b0;
      ovf      <= '0;
    end else begin
      rd_valid <= rd_ok_s;
      wr_drop  <= wr_en && !wr_ok_s;
      ovf      <= (ovf & ~ovf_clr) | ovf_set_s;
      if (rd_ok_s) begin
        rd_data <= mem_r[rd_addr_s];
      end else begin
        rd_data <= rd_data;
      end
    end
  end

endmodule

// File: doc/sync_fifo_mc.md
# sync_fifo_mc

Single-clock, multi-channel FIFO with a soft "full" threshold and hard-limit write-past protection. It provides NUM_CH independent first-in-first-out queues in one shared storage array, with one write port and one read port, each steered by a channel index. It sits between a multi-source producer and a single arbitrated consumer in the same clock domain. Writes beyond a channel's hard capacity are dropped and flagged, never corrupt stored data.

## Interface
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 4, per-channel depth DEPTH = 2**ADDR_WIDTH.
- RESERVE, 8, slots held back below DEPTH before `full` asserts; legal range 0..DEPTH-1.
- NUM_CH, 4, channel count, ≥1; CHW = max(1, clog2(NUM_CH)).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_ch  in  CHW  target channel of write.
- wr_data  in  DATA_WIDTH  write word.
- wr_drop  out  1  registered pulse: write in previous cycle was discarded.
- full  out  NUM_CH  per channel: level ≥ DEPTH-RESERVE.
- ovf  out  NUM_CH  sticky per-channel overflow.
- ovf_clr  in  NUM_CH  clears matching `ovf` bits.
- rd_en  in  1  read request.
- rd_ch  in  CHW  source channel of read.
- rd_data  out  DATA_WIDTH  read word, registered.
- rd_valid  out  1  `rd_data` carries a newly popped word.
- empty  out  NUM_CH  per channel: level == 0.
- has_data  out  NUM_CH  per channel: level ≠ 0 (= ~empty).
- level  out  NUM_CH*(ADDR_WIDTH+1)  per-channel occupancy, channel c at bits [c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].

## Operation
- Storage: NUM_CH*DEPTH words, address {ch, ptr}; per channel a write pointer, read pointer (ADDR_WIDTH bits, natural wrap) and level counter (ADDR_WIDTH+1 bits, 0..DEPTH).
- `full` is advisory: writes are still accepted while `full`=1 until level reaches DEPTH.
- Write accepted iff wr_en=1, wr_ch < NUM_CH, and (level < DEPTH, or a read of the same channel is accepted in the same cycle).
- Write rejected with wr_en=1: `wr_drop` pulses next cycle; if wr_ch < NUM_CH, `ovf[wr_ch]` sets. Out-of-range wr_ch drops without setting `ovf`.
- Read accepted iff rd_en=1, rd_ch < NUM_CH, level(rd_ch) ≠ 0 at the start of the cycle. A word written that same cycle is not readable until the next cycle.
- Read rejected: no pointer/level change, `rd_valid`=0, `rd_data` holds.
- Same-channel simultaneous accepted read and write: level unchanged, both pointers advance.
- `ovf` set has priority over `ovf_clr` in the same cycle.
- `empty`, `has_data`, `full` are combinational decodes of registered `level`.

## Timing
- Reset (rst_n=0, asynchronous): all pointers/levels 0, empty=all 1, has_data=0, full=0 (=all 1 only if RESERVE would make threshold 0, not legal), ovf=0, wr_drop=0, rd_valid=0, rd_data=0. Stored words not cleared. Reset mid-operation discards all queued data.
- Write at edge N: `level` +1, flags update after edge N; word readable by a read issued in cycle N+1.
- Read issued at edge N: `rd_data`/`rd_valid` valid after edge N (one-cycle latency); `rd_valid` is a one-cycle pulse per accepted read; back-to-back reads give one word per cycle.
- `wr_drop` asserted for exactly the cycle after each dropped write.
- Throughput: one write and one read per cycle, any channel combination.

## Test plan
- Reset: hold rst_n=0 mid-traffic → all outputs at reset values immediately, without waiting for a clock edge; level all 0; empty=4'b1111.
- Write-past: 20 consecutive writes to ch0, data 0..19, no reads → full[0] rises after 8th write (level 8), level saturates at 16, wr_drop pulses 4 times, ovf[0]=1; then 16 reads → rd_data 0..15, then empty[0]=1; a 17th read gives no rd_valid.
- Channel independence: interleave writes ch0=0xA0.., ch3=0x30.., reads alternating ch3/ch0 → each stream in order, no cross-talk; ovf stays 0.
- Full boundary: ch1 at level 16, same-cycle read+write of ch1 → write accepted, no wr_drop, level stays 16, popped word is oldest.
- Wrap-around: 3 rounds of 12 writes/12 reads on ch2 (data 0..35) → all 36 words read in order, pointers wrap cleanly.
- Overflow clear/priority: ovf[0]=1, pulse ovf_clr[0] → clears; ovf_clr[0] coincident with a dropped ch0 write → ovf[0] remains 1.
